// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the oversampling UART receiver.
//   - parity mode constants (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - receiver FSM state encoding
//   - helpers for bit-period length and bit-timer counter width
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Clock cycles per line bit (integer division, truncating).
  function automatic int calc_cpb(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Width of a counter running 0..cpb-1.
  function automatic int calc_cnt_w(input int cpb);
    return (cpb <= 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: input synchroniser, bit timer and bit-value sampler.
//   clk, rst      : clock, synchronous active-high reset
//   uart_rxd      : raw asynchronous serial line
//   run           : high while a frame is in progress; low holds the timer at 0
//   rxd_s         : synchronised line (second synchroniser flop)
//   sample_stb    : bit value decision strobe (timer count CPB/2+1)
//   sample_val    : bit value presented with sample_stb
//   boundary_stb  : last cycle of the bit period (count CPB-1)
// Build option UART_RX_MAJORITY_EN: bit value is the 2-of-3 vote of rxd_s at
// counts CPB/2-1, CPB/2 and CPB/2+1; otherwise the value seen at CPB/2 is used.
// The decision strobe sits at CPB/2+1 in both builds so frame latency matches.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CPB = 16,
  parameter int CW  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rxd,
  input  logic run,
  output logic rxd_s,
  output logic sample_stb,
  output logic sample_val,
  output logic boundary_stb
);

  localparam logic [CW-1:0] CNT_STB  = CW'(CPB/2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  logic          sync1;
  logic [1:0]    hist;   // rxd_s delayed by one ([0]) and two ([1]) cycles
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
      hist  <= 2'b11;
      cnt   <= '0;
    end else begin
      sync1 <= uart_rxd;
      rxd_s <= sync1;
      hist  <= {hist[0], rxd_s};
      if (!run || cnt == CNT_LAST) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
    end
  end

  assign sample_stb   = run && (cnt == CNT_STB);
  assign boundary_stb = run && (cnt == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  // At count CPB/2+1: hist[1] = count-2 sample, hist[0] = count-1, rxd_s = now.
  assign sample_val = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
  assign sample_val = hist[0];
`endif

endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: parametrised UART receiver with false-start rejection, parity
// and framing checks, break detection and a ready/valid output register.
//   clk, rst      : clock, synchronous active-high reset
//   uart_rxd      : asynchronous serial line, idle high
//   rx_en         : receiver enable; low aborts any frame in progress
//   m_data        : received word, LSB first on the line
//   m_valid/ready : output handshake
//   frame_err     : a stop bit sampled low (with m_valid)
//   parity_err    : parity mismatch (with m_valid)
//   break_det     : data, parity and first stop bit all low (with m_valid)
//   overrun       : sticky, a completed frame was dropped; overrun_clr clears
// Build option UART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rxd,
  input  logic                    rx_en,
  output logic [PAYLOAD_BITS-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    break_det,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int CPB = calc_cpb(CLK_HZ, BIT_RATE);
  localparam int CW  = calc_cnt_w(CPB);
  localparam int IW  = $clog2(PAYLOAD_BITS);

  rx_state_e               state;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [IW-1:0]           bit_idx;
  logic                    stop_idx;   // 1 while in the second stop bit
  logic                    par_bit;
  logic                    stop0;      // first stop bit value (two-stop-bit frames)
  logic                    ferr_acc;

  logic rxd_s, sample_stb, sample_val, boundary_stb;

  uart_rx_sampler #(.CPB(CPB), .CW(CW)) u_sampler (
    .clk          (clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .run          (state != ST_IDLE),
    .rxd_s        (rxd_s),
    .sample_stb   (sample_stb),
    .sample_val   (sample_val),
    .boundary_stb (boundary_stb)
  );

  // Frame completion is taken at the last stop-bit sample, not its boundary,
  // so the FSM is back in IDLE in time for a back-to-back start bit.
  logic last_stop, frame_done, first_stop, done_ferr, done_perr, done_brk;

  always_comb begin
    last_stop  = (STOP_BITS == 1) || stop_idx;
    frame_done = rx_en && (state == ST_STOP) && sample_stb && last_stop;
    first_stop = stop_idx ? stop0 : sample_val;
    done_ferr  = ferr_acc | ~sample_val;
    done_perr  = 1'b0;
    if (PARITY == PAR_EVEN) done_perr =  (^{shreg, par_bit});
    if (PARITY == PAR_ODD)  done_perr = ~(^{shreg, par_bit});
    done_brk   = ~(|shreg) & ((PARITY == PAR_NONE) | ~par_bit) & ~first_stop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      stop0    <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (!rx_en) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!rxd_s) begin
          state    <= ST_START;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          par_bit  <= 1'b0;
          ferr_acc <= 1'b0;
        end
        ST_START: begin
          if (sample_stb && sample_val) state <= ST_IDLE;  // false start
          else if (boundary_stb)        state <= ST_DATA;
        end
        ST_DATA: begin
          if (sample_stb) shreg <= {sample_val, shreg[PAYLOAD_BITS-1:1]};
          if (boundary_stb) begin
            if (bit_idx == IW'(PAYLOAD_BITS-1))
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_PARITY: begin
          if (sample_stb)   par_bit <= sample_val;
          if (boundary_stb) state   <= ST_STOP;
        end
        ST_STOP: begin
          if (sample_stb) begin
            if (last_stop) state <= ST_IDLE;
            else begin
              stop0    <= sample_val;
              ferr_acc <= ~sample_val;
            end
          end
          if (boundary_stb) stop_idx <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: a completing frame loads when the register is empty or
  // being drained this cycle; otherwise it is dropped and overrun is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (frame_done && (!m_valid || m_ready)) begin
        m_data     <= shreg;
        m_valid    <= 1'b1;
        frame_err  <= done_ferr;
        parity_err <= done_perr;
        break_det  <= done_brk;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (frame_done && m_valid && !m_ready) overrun <= 1'b1;
      else if (overrun_clr)                  overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: three instances (8N1, 8E1, 8N2), 16 clocks
// per bit. m_valid rising edges are logged with the cycle count so frame
// latency can be compared against hand-computed values.
module tb_uart_rx_ovs;

  localparam int CLK = 1_600_000;
  localparam int BR  = 100_000;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rxd = 3'b111;
  logic       rx_en = 1'b1, m_ready = 1'b1, overrun_clr = 1'b0;

  logic [7:0] data0, data1, data2;
  logic valid0, valid1, valid2, fe0, fe1, fe2, pe0, pe1, pe2, bd0, bd1, bd2, ov0, ov1, ov2;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_ovs #(.CLK_HZ(CLK), .BIT_RATE(BR), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[0]), .rx_en(rx_en), .m_data(data0), .m_valid(valid0),
    .m_ready(m_ready), .frame_err(fe0), .parity_err(pe0), .break_det(bd0), .overrun(ov0),
    .overrun_clr(overrun_clr));
  uart_rx_ovs #(.CLK_HZ(CLK), .BIT_RATE(BR), .PAYLOAD_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[1]), .rx_en(rx_en), .m_data(data1), .m_valid(valid1),
    .m_ready(m_ready), .frame_err(fe1), .parity_err(pe1), .break_det(bd1), .overrun(ov1),
    .overrun_clr(overrun_clr));
  uart_rx_ovs #(.CLK_HZ(CLK), .BIT_RATE(BR), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[2]), .rx_en(rx_en), .m_data(data2), .m_valid(valid2),
    .m_ready(m_ready), .frame_err(fe2), .parity_err(pe2), .break_det(bd2), .overrun(ov2),
    .overrun_clr(overrun_clr));

  typedef struct { int cyc; logic [7:0] data; logic fe, pe, bd; } cap_t;
  cap_t q0[$], q1[$], q2[$];
  logic pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
  int   vc0 = 0;

  always @(negedge clk) begin
    if (valid0 && !pv0) q0.push_back('{cyc, data0, fe0, pe0, bd0});
    if (valid1 && !pv1) q1.push_back('{cyc, data1, fe1, pe1, bd1});
    if (valid2 && !pv2) q2.push_back('{cyc, data2, fe2, pe2, bd2});
    if (valid0) vc0 <= vc0 + 1;
    pv0 <= valid0; pv1 <= valid1; pv2 <= valid2;
  end

  // Start bit is driven at the current negedge; returns cyc at that moment.
  // par < 0: no parity bit. gbit >= 0: invert that data bit for one cycle at
  // offset 9, which is what the synchronised line shows at timer count CPB/2.
  task automatic send_frame(input int sel, input logic [7:0] d, input int par,
                            input int nstop, input int gbit, output int start);
    start = cyc;
    rxd[sel] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < CPB; j++) begin
        rxd[sel] = (i == gbit && j == 9) ? ~d[i] : d[i];
        @(negedge clk);
      end
    if (par >= 0) begin
      rxd[sel] = par[0];
      repeat (CPB) @(negedge clk);
    end
    rxd[sel] = 1'b1;
    repeat (CPB * nstop) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (data0 !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", data0); end
    n_chk++; if ({valid0, valid1, valid2} !== 3'b000) begin n_fail++; $display("FAIL reset_valid got %b exp 000", {valid0, valid1, valid2}); end
    n_chk++; if ({fe0, pe0, bd0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {fe0, pe0, bd0}); end
    n_chk++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", ov0); end
  endtask

  task automatic test_basic;
    int s, b, v;
    b = q0.size(); v = vc0;
    send_frame(0, 8'hA5, -1, 1, -1, s);
    repeat (CPB) @(negedge clk);
    n_chk++; if (q0.size() - b !== 1) begin n_fail++; $display("FAIL basic_count got %0d exp 1", q0.size() - b); end
    n_chk++; if (q0[b].data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h exp a5", q0[b].data); end
    n_chk++; if ({q0[b].fe, q0[b].pe, q0[b].bd} !== 3'b000) begin n_fail++; $display("FAIL basic_flags got %b exp 000", {q0[b].fe, q0[b].pe, q0[b].bd}); end
    n_chk++; if (q0[b].cyc - s !== 157) begin n_fail++; $display("FAIL basic_latency got %0d exp 157", q0[b].cyc - s); end
    n_chk++; if (vc0 - v !== 1) begin n_fail++; $display("FAIL basic_valid_len got %0d exp 1", vc0 - v); end
  endtask

  task automatic test_parity;
    int s, b;
    b = q1.size();
    send_frame(1, 8'h03, 1, 1, -1, s);
    send_frame(1, 8'h03, 0, 1, -1, s);
    repeat (CPB) @(negedge clk);
    n_chk++; if (q1.size() - b !== 2) begin n_fail++; $display("FAIL par_count got %0d exp 2", q1.size() - b); end
    n_chk++; if (q1[b].data !== 8'h03 || q1[b].pe !== 1'b1) begin n_fail++; $display("FAIL par_bad got %h/%b exp 03/1", q1[b].data, q1[b].pe); end
    n_chk++; if (q1[b+1].data !== 8'h03 || q1[b+1].pe !== 1'b0) begin n_fail++; $display("FAIL par_good got %h/%b exp 03/0", q1[b+1].data, q1[b+1].pe); end
    n_chk++; if (q1[b+1].cyc - s !== 173) begin n_fail++; $display("FAIL par_latency got %0d exp 173", q1[b+1].cyc - s); end
  endtask

  task automatic test_break;
    int s, b;
    b = q0.size();
    s = cyc;
    rxd[0] = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (16 * CPB) @(negedge clk);
    n_chk++; if (q0[b].data !== 8'h00 || q0[b].bd !== 1'b1 || q0[b].fe !== 1'b1)
      begin n_fail++; $display("FAIL break_frame got %h bd=%b fe=%b exp 00 1 1", q0[b].data, q0[b].bd, q0[b].fe); end
    n_chk++; if (q0[b].cyc - s !== 157) begin n_fail++; $display("FAIL break_latency got %0d exp 157", q0[b].cyc - s); end
    send_frame(0, 8'h55, -1, 1, -1, s);
    repeat (CPB) @(negedge clk);
    n_chk++; if (q0[$].data !== 8'h55 || {q0[$].fe, q0[$].pe, q0[$].bd} !== 3'b000)
      begin n_fail++; $display("FAIL after_break got %h %b exp 55 000", q0[$].data, {q0[$].fe, q0[$].pe, q0[$].bd}); end
  endtask

  task automatic test_overrun;
    int s, b;
    b = q0.size();
    m_ready = 1'b0;
    send_frame(0, 8'h11, -1, 1, -1, s);
    repeat (2 * CPB) @(negedge clk);
    send_frame(0, 8'h22, -1, 1, -1, s);
    repeat (2 * CPB) @(negedge clk);
    n_chk++; if (data0 !== 8'h11 || valid0 !== 1'b1) begin n_fail++; $display("FAIL ovr_hold got %h/%b exp 11/1", data0, valid0); end
    n_chk++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b exp 1", ov0); end
    n_chk++; if (q0.size() - b !== 1) begin n_fail++; $display("FAIL ovr_count got %0d exp 1", q0.size() - b); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_chk++; if (ov0 !== 1'b0 || valid0 !== 1'b1) begin n_fail++; $display("FAIL ovr_clr got ov=%b v=%b exp 0 1", ov0, valid0); end
    m_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL ovr_accept got %b exp 0", valid0); end
  endtask

  task automatic test_glitch;
    int s, b;
    b = q0.size();
    rxd[0] = 1'b0;
    repeat (5) @(negedge clk);   // ~0.3 bit
    rxd[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_chk++; if (q0.size() !== b) begin n_fail++; $display("FAIL false_start got %0d frames exp 0", q0.size() - b); end
    send_frame(0, 8'hC3, -1, 1, 0, s);
    repeat (CPB) @(negedge clk);
`ifdef UART_RX_MAJORITY_EN
    n_chk++; if (q0[b].data !== 8'hC3) begin n_fail++; $display("FAIL glitch_vote got %h exp c3", q0[b].data); end
`else
    n_chk++; if (q0[b].data !== 8'hC2) begin n_fail++; $display("FAIL glitch_single got %h exp c2", q0[b].data); end
`endif
  endtask

  task automatic test_back_to_back;
    int s1, s2, b;
    b = q2.size();
    send_frame(2, 8'h01, -1, 2, -1, s1);
    send_frame(2, 8'h80, -1, 2, -1, s2);
    repeat (CPB) @(negedge clk);
    n_chk++; if (q2.size() - b !== 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", q2.size() - b); end
    n_chk++; if (q2[b].data !== 8'h01 || q2[b+1].data !== 8'h80) begin n_fail++; $display("FAIL b2b_order got %h %h exp 01 80", q2[b].data, q2[b+1].data); end
    n_chk++; if (q2[b].cyc - s1 !== 173 || q2[b+1].cyc - s2 !== 173) begin n_fail++; $display("FAIL b2b_latency got %0d %0d exp 173", q2[b].cyc - s1, q2[b+1].cyc - s2); end
    // Second pair: reset lands in the data bits of the 0x80 frame.
    b = q2.size();
    send_frame(2, 8'h01, -1, 2, -1, s1);
    rxd[2] = 1'b0;
    repeat (6 * CPB) @(negedge clk);   // start bit + data bits 0..4 (all 0)
    rxd[2] = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    n_chk++; if (q2.size() - b !== 1) begin n_fail++; $display("FAIL rst_midframe got %0d frames exp 1", q2.size() - b); end
    n_chk++; if (data2 !== 8'h00 || valid2 !== 1'b0 || {fe2, pe2, bd2, ov2} !== 4'b0000)
      begin n_fail++; $display("FAIL rst_outputs got %h v=%b f=%b exp 00 0 0000", data2, valid2, {fe2, pe2, bd2, ov2}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_parity;
    test_break;
    test_overrun;
    test_glitch;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
Next-generation UART receiver, parametrised in baud rate, payload width, parity mode and stop-bit count. Adds several features over a bare receiver:
- false-start rejection
- parity and framing checks
- break detection
- a ready/valid output register with overrun reporting
Sits between the board RX pin and the byte-stream consumer (FIFO write side).

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BIT_RATE, 115200, line rate in bit/s; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division), must be >= 8
PAYLOAD_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  reset
uart_rxd  in  1  asynchronous serial line, idle high
rx_en  in  1  receiver enable
m_data  out  PAYLOAD_BITS  received word, LSB = first bit on the line
m_valid  out  1  m_data and flags valid
m_ready  in  1  consumer accepts the word
frame_err  out  1  stop bit sampled low (qualified by m_valid)
parity_err  out  1  parity mismatch (qualified by m_valid); always 0 when PARITY = 0
break_det  out  1  break frame (qualified by m_valid)
overrun  out  1  sticky: a completed frame was dropped
overrun_clr  in  1  single-cycle pulse clears overrun

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. rst = 1 on a clk edge sets:
  - FSM = IDLE, counters = 0, synchroniser flops = 1
  - m_data = 0, m_valid = 0, all flags = 0, overrun = 0
- Input synchroniser: uart_rxd passes through a 2-flop synchroniser; all decisions use the second flop (rxd_s).
- Bit timer: cycle counter 0..CYCLES_PER_BIT-1, restarted on entering START. Sample strobe fires at count CYCLES_PER_BIT/2; bit boundary at CYCLES_PER_BIT-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when rxd_s = 0 and rx_en = 1.
  - START: sample at mid-bit. Sample = 1 -> false start, back to IDLE, nothing reported. Sample = 0 -> DATA at the bit boundary.
  - DATA: shift in PAYLOAD_BITS samples, LSB first. After the last boundary go to PARITY if PARITY != 0, else STOP.
  - PARITY: sample one bit. Error if XOR(data, parity bit) != 0 for even, or == 0 for odd.
  - STOP: sample STOP_BITS bits; any 0 sets frame_err.
  - Exit from STOP: at the mid-bit sample of the last stop bit, not at its boundary. The frame completes and the FSM returns to IDLE, so a back-to-back start bit is caught.
- break_det = 1 when all of these sampled 0: data bits, parity bit (if present) and first stop bit. frame_err is also 1 in that case.
- Completion and latency: m_valid rises on the cycle after the last stop-bit sample strobe.
- Output register and handshake:
  - m_valid holds, and m_data and flags stay stable, until a cycle with m_valid & m_ready. After that handshake m_valid = 0 unless a new frame loads in the same cycle.
  - Completion while m_valid = 1 and m_ready = 0: the new frame is dropped, the held word is kept, and overrun is set.
  - Completion in the same cycle as a handshake: the new frame loads and overrun is unchanged.
  - overrun clears on overrun_clr. If a set and overrun_clr coincide, set wins.
- rx_en:
  - rx_en = 0 forces the FSM to IDLE on the next edge and discards any partial frame.
  - The output register and handshake keep operating.
  - The synchroniser always runs.
- Reset mid-frame: the frame is discarded and no m_valid pulse occurs.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each bit value is the 2-of-3 majority of rxd_s at counts CYCLES_PER_BIT/2-1, /2 and /2+1. Start-bit validation uses the same vote.
- Undefined: single sample at CYCLES_PER_BIT/2.
- Latency is identical in both builds; m_valid timing is referenced to the /2+1 strobe in both.

Decomposition:
- Package uart_pkg:
  - parity mode constants (PAR_NONE / PAR_EVEN / PAR_ODD)
  - FSM state encoding
  - function computing CYCLES_PER_BIT and counter width ($clog2)
- Sub-module uart_rx_sampler: synchroniser, bit-timer counter, sample strobe, optional majority vote. Outputs sample_stb, sample_val and boundary_stb to the FSM.

Test Plan:
- 8N1, 115200: send 0xA5 with m_ready = 1 -> m_data = 0xA5, m_valid high 1 cycle, all flags 0, rising one cycle after the stop-bit mid-sample.
- PARITY = 1 (even): send 0x03 with parity bit 1 -> parity_err = 1, m_data = 0x03; with parity bit 0 -> parity_err = 0.
- Line low for 12 bit times -> m_data = 0x00, break_det = 1, frame_err = 1. Then a valid 0x55 -> received correctly with flags 0.
- m_ready = 0, send 0x11 then 0x22 -> m_data stays 0x11, overrun = 1. Pulse overrun_clr -> overrun = 0. Raise m_ready -> 0x11 accepted, m_valid = 0.
- 0.3-bit low glitch on idle line -> no m_valid. With UART_RX_MAJORITY_EN, a one-cycle mid-bit glitch inside a data bit does not corrupt 0xC3.
- STOP_BITS = 2: back-to-back 0x01, 0x80 at full rate -> both delivered in order. Assert rst mid-second-frame -> no second m_valid, outputs at reset values.
